axis_monitor: RTL and testbench
===============================

AXIS_MONITOR -- requirements
Module: axis_monitor

Interface
REQ-001 Parameter C_AXIS_DATA_WIDTH, default 32: TDATA width in bits; SHALL be a multiple of 8.
REQ-002 Parameter C_AXIS_DEST_WIDTH, default 2: TDEST width; channel count NCH = 2**C_AXIS_DEST_WIDTH.
REQ-003 Parameter F_MAX_PACKET, default 0: maximum packet bytes per channel; 0 disables the check.
REQ-004 Parameter F_MIN_PACKET, default 0: minimum packet bytes per channel; 0 disables the check.
REQ-005 Parameter F_MAX_STALL, default 0: maximum consecutive stall cycles; 0 disables the check.
REQ-006 Parameter LGCOUNT, default 16: width of the per-channel byte and packet counters.
REQ-007 Ports, in order:
- i_aclk, in, 1: the single clock; all logic on its rising edge.
- i_aresetn, in, 1: synchronous, active-low reset.
- i_tvalid, i_tready, i_tlast, in, 1: monitored stream handshake and end-of-packet.
- i_tdata, in, C_AXIS_DATA_WIDTH: monitored data.
- i_tkeep, i_tstrb, in, C_AXIS_DATA_WIDTH/8: byte qualifiers.
- i_tdest, in, C_AXIS_DEST_WIDTH: channel select.
- i_clear, in, 1: clears sticky errors.
- i_sel, in, C_AXIS_DEST_WIDTH: status readout channel.
- o_err, out, 6: sticky error flags.
- o_err_dest, out, C_AXIS_DEST_WIDTH: TDEST of the first error.
- o_sel_bytes, out, LGCOUNT: in-progress byte count of channel i_sel.
- o_sel_pkts, out, LGCOUNT: completed packet count of channel i_sel.
- o_stall, out, LGCOUNT: current stall run length.
REQ-008 The block SHALL be passive: it SHALL never drive the monitored stream.

Function
REQ-009 Handshake (HS) SHALL mean i_tvalid && i_tready; stall SHALL mean i_tvalid && !i_tready.
REQ-010 vbytes SHALL equal the count of byte lanes with i_tkeep && i_tstrb, and 0 when !i_tvalid.
REQ-011 Each channel SHALL hold bytes[LGCOUNT] and pkts[LGCOUNT].
REQ-012 On HS with i_tlast, channel i_tdest SHALL clear bytes to 0 and increment pkts.
REQ-013 On HS without i_tlast, channel i_tdest SHALL add vbytes to bytes.
REQ-014 bytes SHALL saturate at all-ones; pkts SHALL wrap modulo 2**LGCOUNT.
REQ-015 Only channel i_tdest SHALL update on an HS; all other channels SHALL hold.
REQ-016 o_sel_bytes and o_sel_pkts SHALL be combinational muxes of the registered counters, with zero-cycle latency from i_sel.
REQ-017 o_stall SHALL increment on each stall cycle, clear on any non-stall cycle, and saturate at all-ones.
REQ-018 The block SHALL register the previous cycle's stream signals and a flag prev_stall.
REQ-019 err[0] STABILITY SHALL be set when prev_stall is true and any of the following holds:
- i_tvalid has dropped;
- i_tlast, i_tdest, i_tkeep or i_tstrb has changed;
- any i_tdata byte whose previous i_tkeep bit was 1 has changed.
REQ-020 Changes in i_tdata bytes whose previous i_tkeep bit was 0 SHALL NOT set err[0].
REQ-021 err[1] RESERVED SHALL be set when i_tvalid && (i_tstrb & ~i_tkeep) != 0.
REQ-022 err[2] TOO_LONG SHALL be set on HS when F_MAX_PACKET > 0 and bytes + vbytes > F_MAX_PACKET; the sum SHALL be computed at LGCOUNT+1 bits.
REQ-023 err[3] TOO_SHORT SHALL be set on HS with i_tlast when F_MIN_PACKET > 0 and bytes + vbytes < F_MIN_PACKET.
REQ-024 err[4] STALL_TIMEOUT SHALL be set when F_MAX_STALL > 0 and o_stall >= F_MAX_STALL.
REQ-025 err[5] RESET_VALID SHALL be set when i_tvalid is high in the first cycle after i_aresetn rises.
REQ-026 A condition detected in cycle N SHALL appear in o_err at cycle N+1.
REQ-027 Error bits SHALL be sticky until i_clear.
REQ-028 i_clear SHALL zero o_err on the next edge; an error detected in the same cycle as i_clear SHALL win, and its bit SHALL be set.
REQ-029 o_err_dest SHALL capture i_tdest when o_err transitions from all-zero to nonzero, and SHALL hold until i_clear.
REQ-030 Counters SHALL NOT be affected by errors or by i_clear.

Reset
REQ-031 While !i_aresetn, the following SHALL be 0 on the next edge: all bytes and pkts counters, o_stall, o_err, o_err_dest, prev_stall.
REQ-032 A reset asserted mid-packet SHALL discard the partial count with no error; the next packet SHALL count from 0.
REQ-033 err[0] and err[5] SHALL not compare against pre-reset history; prev_stall SHALL be 0 in the first cycle after reset.

Verification
REQ-034 DW=32, 3 HS beats on dest 1 (keep=F,F,F with tlast on beat 3) -> bytes[1]=0, pkts[1]=1; bytes[1]=8 after beat 2; dest 0 unchanged.
REQ-035 Stall with keep=4'b0011, then tdata[31:16] changes -> no error; tdata[7:0] changes -> o_err=6'b000001 next cycle, o_err_dest=stall dest.
REQ-036 F_MAX_STALL=4, tvalid high and tready low for 5 cycles -> err[4] set the cycle after o_stall reaches 4.
REQ-037 F_MAX_PACKET=8, F_MIN_PACKET=8: a 12-byte packet sets err[2]; after i_clear, a 4-byte packet sets err[3]; i_clear together with a new error leaves that error's bit set.
REQ-038 Reset mid-packet (bytes[2]=8), then a 4-byte tlast packet on dest 2 -> pkts[2]=1, no err[3] with F_MIN_PACKET=4; tvalid high the first cycle after reset -> err[5].
REQ-039 LGCOUNT=4: 20 bytes without tlast -> bytes saturates at 15; 17 packets -> pkts wraps to 1.

Source files
------------

// File: rtl/axis_monitor.sv
// Passive AXI-Stream protocol monitor: per-TDEST byte/packet counters,
// stall-run tracking and sticky protocol error flags.
module axis_monitor #(
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int C_AXIS_DEST_WIDTH = 2,
  parameter int F_MAX_PACKET      = 0,
  parameter int F_MIN_PACKET      = 0,
  parameter int F_MAX_STALL       = 0,
  parameter int LGCOUNT           = 16
) (
  input  logic                         i_aclk,
  input  logic                         i_aresetn,
  input  logic                         i_tvalid,
  input  logic                         i_tready,
  input  logic                         i_tlast,
  input  logic [C_AXIS_DATA_WIDTH-1:0] i_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] i_tkeep,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0] i_tstrb,
  input  logic [C_AXIS_DEST_WIDTH-1:0] i_tdest,
  input  logic                         i_clear,
  input  logic [C_AXIS_DEST_WIDTH-1:0] i_sel,
  output logic [5:0]                   o_err,
  output logic [C_AXIS_DEST_WIDTH-1:0] o_err_dest,
  output logic [LGCOUNT-1:0]           o_sel_bytes,
  output logic [LGCOUNT-1:0]           o_sel_pkts,
  output logic [LGCOUNT-1:0]           o_stall
);

  localparam int NB  = C_AXIS_DATA_WIDTH / 8;
  localparam int NCH = 2 ** C_AXIS_DEST_WIDTH;
  localparam logic [LGCOUNT-1:0] CNT_MAX   = '1;
  localparam logic [LGCOUNT:0]   MAX_PKT   = (LGCOUNT+1)'(F_MAX_PACKET);
  localparam logic [LGCOUNT:0]   MIN_PKT   = (LGCOUNT+1)'(F_MIN_PACKET);
  localparam logic [LGCOUNT-1:0] MAX_STALL = LGCOUNT'(F_MAX_STALL);

  logic [LGCOUNT-1:0] bytes_q [NCH];
  logic [LGCOUNT-1:0] pkts_q  [NCH];

  logic                         prev_stall;
  logic                         after_reset;
  logic                         prev_last;
  logic [C_AXIS_DEST_WIDTH-1:0] prev_dest;
  logic [NB-1:0]                prev_keep;
  logic [NB-1:0]                prev_strb;
  logic [C_AXIS_DATA_WIDTH-1:0] prev_data;

  logic               hs;
  logic               stall;
  logic [LGCOUNT:0]   vbytes;
  logic [LGCOUNT:0]   sum;
  logic               data_chg;
  logic [5:0]         det;

  assign hs    = i_tvalid && i_tready;
  assign stall = i_tvalid && !i_tready;

  assign o_sel_bytes = bytes_q[i_sel];
  assign o_sel_pkts  = pkts_q[i_sel];

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    vbytes   = '0;
    data_chg = 1'b0;
    if (i_tvalid) begin
      for (int i = 0; i < NB; i++)
        vbytes = vbytes + {{LGCOUNT{1'b0}}, i_tkeep[i] & i_tstrb[i]};
    end
    // Only bytes that were kept while stalled must hold their value.
    for (int i = 0; i < NB; i++)
      if (prev_keep[i] && (i_tdata[8*i +: 8] != prev_data[8*i +: 8]))
        data_chg = 1'b1;
    sum = {1'b0, bytes_q[i_tdest]} + vbytes;

    det    = '0;
    det[0] = prev_stall && (!i_tvalid || (i_tlast != prev_last) || (i_tdest != prev_dest) ||
                            (i_tkeep != prev_keep) || (i_tstrb != prev_strb) || data_chg);
    det[1] = i_tvalid && ((i_tstrb & ~i_tkeep) != '0);
    det[2] = hs && (F_MAX_PACKET > 0) && (sum > MAX_PKT);
    det[3] = hs && i_tlast && (F_MIN_PACKET > 0) && (sum < MIN_PKT);
    det[4] = (F_MAX_STALL > 0) && (o_stall >= MAX_STALL);
    det[5] = after_reset && i_tvalid;
  end

  // NOTE: the counter arrays are small register files, so they are reset like any other state.
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      for (int c = 0; c < NCH; c++) begin
        bytes_q[c] <= '0;
        pkts_q[c]  <= '0;
      end
      o_stall     <= '0;
      o_err       <= '0;
      o_err_dest  <= '0;
      prev_stall  <= 1'b0;
      after_reset <= 1'b1;
    end else begin
      after_reset <= 1'b0;
      prev_stall  <= stall;

      if (hs) begin
        if (i_tlast) begin
          bytes_q[i_tdest] <= '0;
          pkts_q[i_tdest]  <= pkts_q[i_tdest] + LGCOUNT'(1);
        end else begin
          bytes_q[i_tdest] <= sum[LGCOUNT] ? CNT_MAX : sum[LGCOUNT-1:0];
        end
      end

      if (!stall)
        o_stall <= '0;
      else if (o_stall != CNT_MAX)
        o_stall <= o_stall + LGCOUNT'(1);

      // A fresh detection overrides a simultaneous clear.
      o_err <= (i_clear ? 6'b0 : o_err) | det;
      if ((det != '0) && ((o_err == '0) || i_clear))
        o_err_dest <= i_tdest;
      else if (i_clear)
        o_err_dest <= '0;
    end
  end

  // Previous-beat history needs no reset: it is only consulted while prev_stall is set.
  always_ff @(posedge i_aclk) begin
    prev_last <= i_tlast;
    prev_dest <= i_tdest;
    prev_keep <= i_tkeep;
    prev_strb <= i_tstrb;
    prev_data <= i_tdata;
  end

endmodule

// File: tb/tb_axis_monitor.sv
// Directed bench for axis_monitor: a vector table for counting/error basics
// plus hand-written sequences for stability, stall timeout, saturation and reset.
module tb_axis_monitor;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        tvalid, tready, tlast, clear;
  logic [31:0] tdata;
  logic [3:0]  tkeep, tstrb;
  logic [1:0]  tdest, sel;

  logic [5:0]  a_err, b_err;
  logic [1:0]  a_err_dest, b_err_dest;
  logic [15:0] a_bytes, a_pkts, a_stall;
  logic [3:0]  b_bytes, b_pkts, b_stall;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  axis_monitor #(.C_AXIS_DATA_WIDTH(32), .C_AXIS_DEST_WIDTH(2), .F_MAX_PACKET(8),
                 .F_MIN_PACKET(8), .F_MAX_STALL(4), .LGCOUNT(16)) dut_a (
    .i_aclk(clk), .i_aresetn(aresetn), .i_tvalid(tvalid), .i_tready(tready),
    .i_tlast(tlast), .i_tdata(tdata), .i_tkeep(tkeep), .i_tstrb(tstrb),
    .i_tdest(tdest), .i_clear(clear), .i_sel(sel), .o_err(a_err),
    .o_err_dest(a_err_dest), .o_sel_bytes(a_bytes), .o_sel_pkts(a_pkts),
    .o_stall(a_stall));

  axis_monitor #(.C_AXIS_DATA_WIDTH(32), .C_AXIS_DEST_WIDTH(2), .F_MAX_PACKET(0),
                 .F_MIN_PACKET(4), .F_MAX_STALL(0), .LGCOUNT(4)) dut_b (
    .i_aclk(clk), .i_aresetn(aresetn), .i_tvalid(tvalid), .i_tready(tready),
    .i_tlast(tlast), .i_tdata(tdata), .i_tkeep(tkeep), .i_tstrb(tstrb),
    .i_tdest(tdest), .i_clear(clear), .i_sel(sel), .o_err(b_err),
    .o_err_dest(b_err_dest), .o_sel_bytes(b_bytes), .o_sel_pkts(b_pkts),
    .o_stall(b_stall));

  typedef struct {
    logic        valid, ready, last, clr;
    logic [3:0]  keep, strb;
    logic [1:0]  dest, sel;
    logic [31:0] data;
    logic [15:0] exp_bytes, exp_pkts;
    logic [5:0]  exp_err;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(input logic v, r, l, c, input logic [3:0] k, s,
                              input logic [1:0] d, sl, input logic [31:0] dat,
                              input logic [15:0] eb, ep, input logic [5:0] ee);
    vec_t t;
    t.valid = v; t.ready = r; t.last = l; t.clr = c; t.keep = k; t.strb = s;
    t.dest = d; t.sel = sl; t.data = dat; t.exp_bytes = eb; t.exp_pkts = ep; t.exp_err = ee;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tvalid = 1'b0; tready = 1'b0; tlast = 1'b0; clear = 1'b0;
    tkeep = 4'h0; tstrb = 4'h0; tdest = 2'd0; tdata = 32'h0;
  endtask

  task automatic beat(input logic v, r, l, input logic [3:0] k, input logic [1:0] d,
                      input logic [31:0] dat);
    tvalid = v; tready = r; tlast = l; tkeep = k; tstrb = k; tdest = d; tdata = dat;
  endtask

  task automatic do_reset();
    idle();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    idle();
    sel = 2'd0;
    do_reset();

    // Reset state
    check("reset_err", 32'(a_err), 32'h0);
    check("reset_err_dest", 32'(a_err_dest), 32'h0);
    check("reset_stall", 32'(a_stall), 32'h0);
    for (int c = 0; c < 4; c++) begin
      sel = 2'(c);
      #1;
      check($sformatf("reset_bytes%0d", c), 32'(a_bytes), 32'h0);
      check($sformatf("reset_pkts%0d", c), 32'(a_pkts), 32'h0);
    end

    //                 v     r     l     clr   keep  strb  dest  sel   data          bytes pkts err
    vecs[0]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 2'd1, 2'd1, 32'h0,        16'd4, 16'd0, 6'b000000);
    vecs[1]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'hF, 4'hF, 2'd1, 2'd1, 32'h0,        16'd8, 16'd0, 6'b000000);
    vecs[2]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 2'd1, 2'd1, 32'h0,        16'd0, 16'd1, 6'b000100);
    vecs[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 2'd0, 32'h0,        16'd0, 16'd0, 6'b000100);
    vecs[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2'd0, 2'd1, 32'h0,        16'd0, 16'd1, 6'b000100);
    vecs[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 2'd0, 2'd1, 32'h0,        16'd0, 16'd1, 6'b000000);
    vecs[6]  = mk(1'b1, 1'b1, 1'b1, 1'b0, 4'hF, 4'hF, 2'd0, 2'd0, 32'h0,        16'd0, 16'd1, 6'b001000);
    vecs[7]  = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 4'h3, 2'd2, 2'd2, 32'h0,        16'd2, 16'd0, 6'b001000);
    vecs[8]  = mk(1'b1, 1'b1, 1'b0, 1'b1, 4'h3, 4'h7, 2'd2, 2'd2, 32'h0,        16'd4, 16'd0, 6'b000010);
    vecs[9]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 4'hF, 4'hF, 2'd3, 2'd3, 32'h12345678, 16'd0, 16'd0, 6'b000000);
    vecs[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'hF, 4'hF, 2'd3, 2'd3, 32'h12345678, 16'd0, 16'd0, 6'b000001);

    for (int i = 0; i < 11; i++) begin
      tvalid = vecs[i].valid; tready = vecs[i].ready; tlast = vecs[i].last;
      clear = vecs[i].clr; tkeep = vecs[i].keep; tstrb = vecs[i].strb;
      tdest = vecs[i].dest; sel = vecs[i].sel; tdata = vecs[i].data;
      tick();
      check($sformatf("vec%0d_bytes", i), 32'(a_bytes), 32'(vecs[i].exp_bytes));
      check($sformatf("vec%0d_pkts", i), 32'(a_pkts), 32'(vecs[i].exp_pkts));
      check($sformatf("vec%0d_err", i), 32'(a_err), 32'(vecs[i].exp_err));
    end
    check("vec10_err_dest", 32'(a_err_dest), 32'd3);

    // Stability: unkept bytes may change, kept bytes may not
    idle(); clear = 1'b1; tick(); tick(); clear = 1'b0;
    check("stab_cleared", 32'(a_err), 32'h0);
    beat(1'b1, 1'b0, 1'b0, 4'h3, 2'd2, 32'hAABBCCDD);
    tick();
    tdata = 32'h1122CCDD;
    tick();
    check("stab_unkept_change", 32'(a_err), 32'h0);
    tdata = 32'h1122CCEE;
    tick();
    check("stab_kept_change", 32'(a_err), 32'h01);
    check("stab_err_dest", 32'(a_err_dest), 32'd2);

    // Stall timeout at F_MAX_STALL = 4
    idle(); clear = 1'b1; tick(); tick(); clear = 1'b0;
    check("stall_cleared", 32'(a_err), 32'h0);
    beat(1'b1, 1'b0, 1'b0, 4'hF, 2'd1, 32'hCAFEF00D);
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("stall_count%0d", k), 32'(a_stall), 32'(k));
      if (k == 4) check("stall_err_before", 32'(a_err), 32'h00);
      if (k == 5) check("stall_err_after", 32'(a_err), 32'h10);
    end
    tready = 1'b1; tvalid = 1'b0;
    tick();
    check("stall_release", 32'(a_stall), 32'h0);

    // LGCOUNT=4: byte saturation and packet wrap
    do_reset();
    sel = 2'd1;
    for (int k = 1; k <= 5; k++) begin
      beat(1'b1, 1'b1, 1'b0, 4'hF, 2'd1, 32'h0);
      tick();
      if (k >= 4) check($sformatf("sat_bytes_beat%0d", k), 32'(b_bytes), 32'd15);
    end
    check("sat_pkts", 32'(b_pkts), 32'd0);
    sel = 2'd3;
    for (int k = 1; k <= 17; k++) begin
      beat(1'b1, 1'b1, 1'b1, 4'hF, 2'd3, 32'h0);
      tick();
      if (k == 16) check("wrap_pkts16", 32'(b_pkts), 32'd0);
      if (k == 17) check("wrap_pkts17", 32'(b_pkts), 32'd1);
    end
    sel = 2'd1;
    #1;
    check("wrap_other_hold", 32'(b_bytes), 32'd15);

    // Reset mid-packet, then tvalid high in the first cycle after reset
    do_reset();
    sel = 2'd2;
    beat(1'b1, 1'b1, 1'b0, 4'hF, 2'd2, 32'h0);
    tick();
    tick();
    check("midpkt_bytes", 32'(b_bytes), 32'd8);
    idle();
    aresetn = 1'b0;
    tick();
    check("midpkt_reset_bytes", 32'(b_bytes), 32'd0);
    check("midpkt_reset_err", 32'(b_err), 32'h0);
    aresetn = 1'b1;
    beat(1'b1, 1'b1, 1'b1, 4'hF, 2'd2, 32'h0);
    tick();
    check("postreset_pkts", 32'(b_pkts), 32'd1);
    check("postreset_bytes", 32'(b_bytes), 32'd0);
    check("postreset_err", 32'(b_err), 32'h20);
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
